// File: rtl/finv_nr_if.sv
// Operand/result handshake bundle for finv_nr.
//   in_valid/in_ready/x      : operand channel (master drives x and in_valid)
//   out_valid/out_ready/y    : result channel (master drives out_ready)
// master = the requester (FPU sequencer or bench), slave = the finv_nr unit.
interface finv_nr_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport master (
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y
  );

  modport slave (
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y
  );
endinterface

// File: rtl/finv_nr.sv
// Iterative single-precision reciprocal: a LUT seed on the leading mantissa
// bits refined by ITERS Newton-Raphson steps y' = y*(2 - x*y) in fixed point,
// with IEEE special cases and exponent flush. One operation in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - finv_nr_if.slave: in_valid/in_ready/x operand, out_valid/out_ready/y result
module finv_nr #(
  parameter int unsigned LUT_BITS = 6,
  parameter int unsigned ITERS    = 2,
  parameter int unsigned FRAC     = 28
) (
  input  logic     clk,
  input  logic     rst,
  finv_nr_if.slave bus
);
  localparam int unsigned YW   = FRAC + 2;      // Q2.FRAC storage
  localparam int unsigned NLUT = 1 << LUT_BITS;

  typedef logic [YW-1:0] yfix_t;
  typedef enum logic [2:0] {IDLE, SEED, MULA, MULB, PACK, DONE} state_t;
  typedef enum logic [1:0] {C_NORM, C_SUB, C_INF, C_NAN} cls_t;

  localparam yfix_t TWO = {2'b10, {FRAC{1'b0}}};

  // Reciprocal of the interval midpoint 1 + (2i+1)/2^(LUT_BITS+1), in Q1.FRAC.
  function automatic yfix_t seed_of(input int i);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (FRAC + LUT_BITS + 1);
    den = (64'd1 << (LUT_BITS + 1)) + 64'(2 * i + 1);
    return yfix_t'(num / den);
  endfunction

  yfix_t lut [NLUT];
  for (genvar g = 0; g < NLUT; g++) begin : g_lut
    assign lut[g] = seed_of(g);
  end

  state_t        state, state_n;
  cls_t          cls;
  logic          s;
  logic [7:0]    e;
  logic [22:0]   m;
  yfix_t         yr, t, d;
  logic [2:0]    k;
  logic          rdy_q, ov_q;
  logic [31:0]   y_q, res;
  logic [YW+23:0]  pa;
  logic [2*YW-1:0] pb;
  logic          accept, take, ld_seed, do_mula, do_mulb, do_pack;

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.y         = y_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SEED;
      SEED:    state_n = (ITERS == 0) ? PACK : MULA;
      MULA:    state_n = MULB;
      MULB:    state_n = (k + 3'd1 == 3'(ITERS)) ? PACK : MULA;
      PACK:    state_n = DONE;
      DONE:    if (take) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    accept  = 1'b0;
    take    = 1'b0;
    ld_seed = 1'b0;
    do_mula = 1'b0;
    do_mulb = 1'b0;
    do_pack = 1'b0;
    case (state)
      IDLE:    accept  = rdy_q & bus.in_valid;
      SEED:    ld_seed = 1'b1;
      MULA:    do_mula = 1'b1;
      MULB:    do_mulb = 1'b1;
      PACK:    do_pack = 1'b1;
      DONE:    take    = bus.out_ready;
      default: ;
    endcase
  end

  // t = X*y with X = {1,m} in Q1.23; y*(2-t) back to Q1.FRAC
  assign pa = {{YW{1'b0}}, 1'b1, m} * {24'd0, yr};
  assign d  = TWO - t;
  assign pb = {{YW{1'b0}}, yr} * {{YW{1'b0}}, d};

  // Result packing; the arithmetic result is only used for normal non-power-of-two operands.
  always_comb begin
    res = '0;
    case (cls)
      C_SUB: res = {s, 8'hFF, 23'd0};
      C_INF: res = {s, 31'd0};
      C_NAN: res = 32'h7FC0_0000;
      default: begin
        if (m == '0) begin
          if (e != 8'd254) res = {s, 8'd254 - e, 23'd0};
          else             res = {s, 31'd0};
        end else if (e < 8'd253) begin
          // y should sit in (0.5,1); clamp if truncation ever pushes it to an edge
          if (yr[FRAC])        res = {s, 8'd253 - e, {23{1'b1}}};
          else if (!yr[FRAC-1]) res = {s, 8'd253 - e, 23'd0};
          else                 res = {s, 8'd253 - e, yr[FRAC-2 -: 23]};
        end else begin
          res = {s, 31'd0};
        end
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s     <= 1'b0;
      e     <= '0;
      m     <= '0;
      cls   <= C_NORM;
      yr    <= '0;
      t     <= '0;
      k     <= '0;
      rdy_q <= 1'b0;
      ov_q  <= 1'b0;
      y_q   <= '0;
    end else begin
      // in_ready stays low for the first cycle after reset, then tracks IDLE
      rdy_q <= (state_n == IDLE);
      if (accept) begin
        s <= bus.x[31];
        e <= bus.x[30:23];
        m <= bus.x[22:0];
        if (bus.x[30:23] == 8'h00)      cls <= C_SUB;
        else if (bus.x[30:23] == 8'hFF) cls <= (bus.x[22:0] == '0) ? C_INF : C_NAN;
        else                            cls <= C_NORM;
      end
      if (ld_seed) begin
        yr <= lut[m[22 -: LUT_BITS]];
        k  <= '0;
      end
      if (do_mula) t <= yfix_t'(pa >> 23);
      if (do_mulb) begin
        yr <= yfix_t'(pb >> FRAC);
        k  <= k + 3'd1;
      end
      if (do_pack) begin
        y_q  <= res;
        ov_q <= 1'b1;
      end
      if (take) ov_q <= 1'b0;
    end
  end
endmodule
